// File: rtl/cia_pkg.sv
// Shared CIA types: register widths, control register A layout and register addresses.
package cia;

    typedef logic [7:0] reg8_t;
    typedef logic [3:0] reg4_t;

    typedef struct packed {
        logic todin;
        logic spmode;
        logic inmode;
        logic load;
        logic runmode;
        logic outmode;
        logic pbon;
        logic start;
    } cra_t;

    localparam reg4_t       REG_TALO    = 4'h4;
    localparam reg4_t       REG_TAHI    = 4'h5;
    localparam reg4_t       REG_CRA     = 4'hE;
    localparam logic [15:0] TIMER_RESET = 16'hFFFF;

    // LOAD is a strobe, so it is never kept in the stored control value.
    function automatic cra_t cra_store(input reg8_t wr_data);
        cra_t v;
        v      = cra_t'(wr_data);
        v.load = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/cia_count_pipe.sv
// Two-stage count-enable delay line advanced once per phi2 cycle, with a flush for one-shot stops.
module cia_count_pipe (
    input  logic clk,
    input  logic res_n,
    input  logic i_adv,
    input  logic i_en,
    input  logic i_flush,
    output logic o_count
);

    logic [1:0] r_stage;

    // Shift the enable through both stages on each phi2 falling edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_stage <= 2'b00;
        end else if (i_adv) begin
            if (i_flush) begin
                r_stage <= 2'b00;
            end else begin
                r_stage <= {r_stage[0], i_en};
            end
        end
    end

    assign o_count = r_stage[1];

endmodule

// File: rtl/cia_timer_a.sv
// CIA timer A: 16-bit down counter with reload latch, one-shot/continuous modes and PB6 output.
module cia_timer_a
    import cia::*;
(
    input  logic  clk,
    input  logic  res_n,
    input  logic  phi2_up,
    input  logic  phi2_dn,
    input  logic  we,
    input  reg4_t addr,
    input  reg8_t data,
    input  logic  cnt_up,
    output reg8_t regs [0:2],
    output logic  ta_int,
    output logic  txmode,
    output logic  pb6_out,
    output logic  pb6_en
);

    logic [15:0] r_latch;
    logic [15:0] r_counter;
    cra_t        r_cra;
    logic        r_load_pend;
    logic        r_ta_int;
    logic        r_toggle;

    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_wr_cra;
    logic        w_count;
    logic        w_zero;
    logic        w_underflow;
    logic        w_oneshot_stop;
    logic        w_en_in;
    cra_t        w_cra_next;
    logic        w_unused_phi2_up;

    // The bus timing is fully framed by phi2_dn; the rising strobe carries no timer state.
    assign w_unused_phi2_up = phi2_up;

    assign w_wr_lo  = phi2_dn & we & (addr == REG_TALO);
    assign w_wr_hi  = phi2_dn & we & (addr == REG_TAHI);
    assign w_wr_cra = phi2_dn & we & (addr == REG_CRA);

    assign w_zero         = (r_counter == 16'h0000);
    assign w_underflow    = phi2_dn & w_count & ~r_load_pend & w_zero;
    assign w_oneshot_stop = w_underflow & r_cra.runmode;

    // Next control register: a CPU write wins over the one-shot auto-stop.
    always_comb begin
        w_cra_next = r_cra;
        if (w_wr_cra) begin
            w_cra_next = cra_store(data);
        end else if (w_oneshot_stop) begin
            w_cra_next.start = 1'b0;
        end else begin
            w_cra_next = r_cra;
        end
    end

    // Enable is taken from the START value being written, so a start at cycle N counts at N+2.
    assign w_en_in = w_cra_next.start & (w_cra_next.inmode ? cnt_up : 1'b1);

    cia_count_pipe u_count_pipe (
        .clk     (clk),
        .res_n   (res_n),
        .i_adv   (phi2_dn),
        .i_en    (w_en_in),
        .i_flush (w_oneshot_stop),
        .o_count (w_count)
    );

    // Counter, latch, control and output flops, all advanced on the phi2 falling edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_latch     <= TIMER_RESET;
            r_counter   <= TIMER_RESET;
            r_cra       <= cra_t'(8'h00);
            r_load_pend <= 1'b0;
            r_ta_int    <= 1'b0;
            r_toggle    <= 1'b0;
        end else if (phi2_dn) begin
            if (r_load_pend) begin
                r_counter <= r_latch;
            end else if (w_count) begin
                r_counter <= w_zero ? r_latch : (r_counter - 16'd1);
            end
            if (w_wr_lo) begin
                r_latch[7:0] <= data;
            end
            if (w_wr_hi) begin
                r_latch[15:8] <= data;
            end
            if (w_wr_cra & ~r_cra.start & data[0]) begin
                r_toggle <= 1'b1;
            end else if (w_underflow) begin
                r_toggle <= ~r_toggle;
            end
            r_load_pend <= (w_wr_hi & ~r_cra.start) | (w_wr_cra & data[4]);
            r_ta_int    <= w_underflow;
            r_cra       <= w_cra_next;
        end
    end

    assign regs[0] = r_counter[7:0];
    assign regs[1] = r_counter[15:8];
    assign regs[2] = r_cra;
    assign ta_int  = r_ta_int;
    assign txmode  = r_cra.spmode;
    assign pb6_en  = r_cra.pbon;
    assign pb6_out = r_cra.outmode ? r_toggle : r_ta_int;

endmodule
